// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller: funct3 codes,
// FSM state encoding and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Bytes moved by an access; the unsigned variants share the low two bits.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we) funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // True when the access runs past the end of its first word.
  function automatic logic spans_two(input logic [1:0] offset, input logic [2:0] funct3);
    spans_two = ({2'b00, offset} + {1'b0, size_bytes(funct3)}) > 4'd4;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte rotation and strobes, load
// reassembly across up to two captured words, and sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic        second,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  wr_strb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  base_mask;
  logic [7:0]  mask8;
  logic [63:0] rot64;
  logic [63:0] shr64;
  logic [31:0] raw;

  always_comb begin
    base_mask = 8'h0F;
    case (size_bytes(funct3))
      3'd1:    base_mask = 8'h01;
      3'd2:    base_mask = 8'h03;
      default: base_mask = 8'h0F;
    endcase
    // Lanes 0..3 belong to the first word, 4..7 spill into the second.
    mask8   = base_mask << offset;
    wr_strb = second ? mask8[7:4] : mask8[3:0];

    rot64 = {wdata, wdata} << {offset, 3'b000};
    for (int i = 0; i < 4; i++) begin
      lane_wdata[8*i +: 8] = wr_strb[i] ? rot64[32 + 8*i +: 8] : 8'h00;
    end

    shr64 = {rdata1, rdata0} >> {offset, 3'b000};
    raw   = shr64[31:0];
    case (funct3)
      F3_B:    load_data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    load_data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   load_data = {24'h0, raw[7:0]};
      F3_HU:   load_data = {16'h0, raw[15:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller for a byte-lane RAM. Define
// LSU_MISALIGN_EN to split word-crossing accesses into two RAM cycles.
// req handshake: accept on req_valid && req_ready (ready only in IDLE); rsp_valid is a one-cycle pulse with no backpressure.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_en,
  output logic [3:0]  mem_wr,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata0,
  output logic [7:0]  mem_wdata1,
  output logic [7:0]  mem_wdata2,
  output logic [7:0]  mem_wdata3,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1;

  logic        accept;
  logic        req_span;
  logic [29:0] word0, word1;
  logic        req_err;
  logic [3:0]  wr_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  assign accept   = req_valid && req_ready;
  assign req_span = spans_two(req_addr[1:0], req_funct3);
  assign word0    = req_addr[31:2];
  assign word1    = req_addr[31:2] + 30'd1;

  // Range and legality are decided from the live request at accept time.
  always_comb begin
    req_err = !funct3_legal(req_we, req_funct3) ||
              ((word0 >> AWIDTH) != 30'd0) ||
              (req_span && ((word1 >> AWIDTH) != 30'd0));
`ifndef LSU_MISALIGN_EN
    req_err = req_err || req_span;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = req_err ? ST_RESP : ST_ACC0;
`ifdef LSU_MISALIGN_EN
      ST_ACC0: state_d = spans_two(addr_q[1:0], funct3_q) ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_d = ST_RESP;
`else
      ST_ACC0: state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      rdata0_q <= 32'd0;
    end else begin
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
    end
  end

  always_comb begin
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    if (accept) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      err_d    = req_err;
      rdata0_d = 32'd0;
    end else if (state_q == ST_ACC0 && !we_q) begin
      rdata0_d = mem_rdata;
    end
  end

`ifdef LSU_MISALIGN_EN
  logic [31:0] rdata1_q, rdata1_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata1_q <= 32'd0;
    else       rdata1_q <= rdata1_d;
  end

  always_comb begin
    rdata1_d = rdata1_q;
    if (accept)                               rdata1_d = 32'd0;
    else if (state_q == ST_ACC1 && !we_q)     rdata1_d = mem_rdata;
  end

  assign rdata1 = rdata1_q;
`else
  assign rdata1 = 32'd0;
`endif

  lsu_lane_align u_align (
    .offset     (addr_q[1:0]),
    .funct3     (funct3_q),
    .second     (state_q == ST_ACC1),
    .wdata      (wdata_q),
    .rdata0     (rdata0_q),
    .rdata1     (rdata1),
    .wr_strb    (wr_strb),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    mem_en     = 1'b0;
    mem_addr   = 32'd0;
    mem_wr     = 4'd0;
    mem_wdata0 = 8'd0;
    mem_wdata1 = 8'd0;
    mem_wdata2 = 8'd0;
    mem_wdata3 = 8'd0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = 32'd0;
    case (state_q)
      ST_ACC0: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
      end
`ifdef LSU_MISALIGN_EN
      ST_ACC1: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[31:2] + 30'd1, 2'b00};
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'd0 : load_data;
      end
      default: ;
    endcase
    if (mem_en && we_q) begin
      mem_wr     = wr_strb;
      mem_wdata0 = lane_wdata[7:0];
      mem_wdata1 = lane_wdata[15:8];
      mem_wdata2 = lane_wdata[23:16];
      mem_wdata3 = lane_wdata[31:24];
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a zero-initialised byte-lane RAM model;
// covers both builds of LSU_MISALIGN_EN.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_en;
  logic [3:0]  mem_wr;
  logic [31:0] mem_addr, mem_rdata;
  logic [7:0]  mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.AWIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata0(mem_wdata0), .mem_wdata1(mem_wdata1),
    .mem_wdata2(mem_wdata2), .mem_wdata3(mem_wdata3),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // RAM model: 256 words of four byte lanes
  logic [7:0] ram [0:1023];
  logic [7:0] wd [4];
  assign wd[0] = mem_wdata0;
  assign wd[1] = mem_wdata1;
  assign wd[2] = mem_wdata2;
  assign wd[3] = mem_wdata3;
  assign mem_rdata = {ram[{mem_addr[9:2], 2'd3}], ram[{mem_addr[9:2], 2'd2}],
                      ram[{mem_addr[9:2], 2'd1}], ram[{mem_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (mem_en) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_wr[l]) ram[{mem_addr[9:2], 2'(l)}] <= wd[l];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Per-cycle snapshots after an accept, cycle 1 = first cycle after the accept edge
  logic        snap_en   [1:8];
  logic [31:0] snap_addr [1:8];
  logic [3:0]  snap_wr   [1:8];
  logic [31:0] snap_wd   [1:8];
  int          lat;
  logic [31:0] rsp_rd;
  logic        rsp_er;
  logic        any_en;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    @(posedge clk);
    #1;
    // Scramble inputs to show the accepted request was registered
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom();
    req_wdata  = $urandom();
  endtask

  task automatic collect(input int max_cyc);
    lat    = 0;
    any_en = 1'b0;
    rsp_rd = 32'hxxxxxxxx;
    rsp_er = 1'bx;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      snap_en[i]   = mem_en;
      snap_addr[i] = mem_addr;
      snap_wr[i]   = mem_wr;
      snap_wd[i]   = {mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0};
      if (mem_en) any_en = 1'b1;
      if (rsp_valid) begin
        lat    = i;
        rsp_rd = rsp_rdata;
        rsp_er = rsp_err;
        break;
      end
    end
  endtask

  task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp, input int exp_lat);
    issue(1'b0, f3, a, 32'h0);
    collect(8);
    check32({tag, "_lat"}, lat, exp_lat);
    check32({tag, "_rdata"}, rsp_rd, exp);
    check1({tag, "_err"}, rsp_er, 1'b0);
  endtask

  task automatic err_check(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] a);
    issue(we, f3, a, 32'hCAFEF00D);
    collect(8);
    check32({tag, "_lat"}, lat, 1);
    check1({tag, "_err"}, rsp_er, 1'b1);
    check32({tag, "_rdata"}, rsp_rd, 32'h0);
    check1({tag, "_no_en"}, any_en, 1'b0);
  endtask

  logic [4:0] vbits;
  logic       rdy3;
  logic [31:0] held_rd;
  int          seen;

  initial begin
    rstn       = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

    // Reset values while rstn is held low
    #12;
    check1("rst_ready", req_ready, 1'b1);
    check1("rst_mem_en", mem_en, 1'b0);
    check32("rst_mem_wr", {28'h0, mem_wr}, 32'h0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_mem_wdata", {mem_wdata3, mem_wdata2, mem_wdata1, mem_wdata0}, 32'h0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_rsp_rdata", rsp_rdata, 32'h0);
    check1("rst_rsp_err", rsp_err, 1'b0);
    check32("rst_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Aligned word store then load
    issue(1'b1, F3_W, 32'h10, 32'h11223344);
    collect(8);
    check1("sw_en", snap_en[1], 1'b1);
    check32("sw_addr", snap_addr[1], 32'h10);
    check32("sw_wr", {28'h0, snap_wr[1]}, 32'hF);
    check32("sw_wdata", snap_wd[1], 32'h11223344);
    check32("sw_lat", lat, 2);
    check32("sw_rdata", rsp_rd, 32'h0);
    check1("sw_err", rsp_er, 1'b0);
    issue(1'b0, F3_W, 32'h10, 32'h0);
    collect(8);
    check32("lw_wr", {28'h0, snap_wr[1]}, 32'h0);
    check32("lw_lat", lat, 2);
    check32("lw_rdata", rsp_rd, 32'h11223344);

    // Byte store on lane 1 and both extensions
    issue(1'b1, F3_B, 32'h21, 32'hDEADBE80);
    collect(8);
    check32("sb_addr", snap_addr[1], 32'h20);
    check32("sb_wr", {28'h0, snap_wr[1]}, 32'h2);
    check32("sb_wdata", snap_wd[1], 32'h00008000);
    load_check("lb", F3_B, 32'h21, 32'hFFFFFF80, 2);
    load_check("lbu", F3_BU, 32'h21, 32'h00000080, 2);

    // Halfword store on upper lanes and both extensions
    issue(1'b1, F3_H, 32'h22, 32'h12348001);
    collect(8);
    check32("sh_wr", {28'h0, snap_wr[1]}, 32'hC);
    check32("sh_wdata", snap_wd[1], 32'h80010000);
    load_check("lh", F3_H, 32'h22, 32'hFFFF8001, 2);
    load_check("lhu", F3_HU, 32'h22, 32'h00008001, 2);
    load_check("lw20", F3_W, 32'h20, 32'h80018000, 2);

    // Illegal funct3 and out-of-range addresses
    err_check("ld_f3_011", 1'b0, 3'b011, 32'h10);
    err_check("ld_f3_110", 1'b0, 3'b110, 32'h10);
    err_check("st_f3_011", 1'b1, 3'b011, 32'h10);
    err_check("oob_400", 1'b0, F3_W, 32'h400);
    err_check("oob_split_3fe", 1'b0, F3_W, 32'h3FE);
    load_check("top_word_3fc", F3_W, 32'h3FC, 32'h0, 2);

`ifdef LSU_MISALIGN_EN
    // Word store crossing into the next word
    issue(1'b1, F3_W, 32'h0E, 32'hAABBCCDD);
    collect(8);
    check32("ssw_addr0", snap_addr[1], 32'h0C);
    check32("ssw_wr0", {28'h0, snap_wr[1]}, 32'hC);
    check32("ssw_wd0", snap_wd[1], 32'hCCDD0000);
    check32("ssw_addr1", snap_addr[2], 32'h10);
    check32("ssw_wr1", {28'h0, snap_wr[2]}, 32'h3);
    check32("ssw_wd1", snap_wd[2], 32'h0000AABB);
    check32("ssw_lat", lat, 3);
    load_check("slw", F3_W, 32'h0E, 32'hAABBCCDD, 3);
    load_check("slh", F3_H, 32'h0F, 32'hFFFFBBCC, 3);

    // Reset while the second word of a split store is on the bus
    issue(1'b1, F3_W, 32'h2D, 32'h55667788);
    @(negedge clk);
    check32("rs_acc0_wr", {28'h0, mem_wr}, 32'hE);
    @(negedge clk);
    check32("rs_acc1_wr", {28'h0, mem_wr}, 32'h1);
    rstn = 1'b0;
    #1;
    check1("rs_en_low", mem_en, 1'b0);
    check32("rs_wr_low", {28'h0, mem_wr}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check32("rs_no_rsp", seen, 0);
    check1("rs_ready", req_ready, 1'b1);
    load_check("rs_word30", F3_W, 32'h30, 32'h0, 2);
    load_check("rs_word2c", F3_W, 32'h2C, 32'h66778800, 2);
    held_rd = 32'h1122AABB;
`else
    err_check("lh_o3", 1'b0, F3_H, 32'h03);
    err_check("sw_0e", 1'b1, F3_W, 32'h0E);
    err_check("lw_0e", 1'b0, F3_W, 32'h0E);

    // Reset during the store cycle suppresses the write and the response
    issue(1'b1, F3_W, 32'h30, 32'h12345678);
    @(negedge clk);
    check32("rs_acc0_wr", {28'h0, mem_wr}, 32'hF);
    rstn = 1'b0;
    #1;
    check1("rs_en_low", mem_en, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check32("rs_no_rsp", seen, 0);
    check1("rs_ready", req_ready, 1'b1);
    load_check("rs_word30", F3_W, 32'h30, 32'h0, 2);
    held_rd = 32'h11223344;
`endif

    // Held req_valid is accepted again in the IDLE cycle after RESP
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    @(posedge clk);
    vbits = 5'b0;
    rdy3  = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      vbits[i-1] = rsp_valid;
      if (i == 3) rdy3 = req_ready;
      if (i == 5) begin
        rsp_rd    = rsp_rdata;
        req_valid = 1'b0;
      end
    end
    check32("held_pulses", {27'h0, vbits}, 32'h12);
    check1("held_ready_idle", rdy3, 1'b1);
    check32("held_rdata", rsp_rd, held_rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter AWIDTH, default 8: word-address width of the attached byte-lane RAM, used only for the out-of-range check.
REQ-002 clk  in  1: clock; all state updates on the rising edge.
REQ-003 rstn  in  1: reset, asynchronous, active-low.
REQ-004 req_valid  in  1: pipeline load/store request present.
REQ-005 req_ready  out  1: high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
REQ-006 req_we  in  1: 1 = store, 0 = load.
REQ-007 req_funct3  in  3: RV32I width code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 req_addr  in  32: byte address.
REQ-009 req_wdata  in  32: store data, right-aligned.
REQ-010 rsp_valid  out  1: one-cycle completion pulse; there is no backpressure.
REQ-011 rsp_rdata  out  32: extended load data, valid with rsp_valid; 0 for stores.
REQ-012 rsp_err  out  1: illegal funct3 or out-of-range address, valid with rsp_valid.
REQ-013 mem_en, mem_wr[3:0], mem_addr[31:0]  out: RAM enable, per-lane write strobes, and word-aligned address (bits [1:0] always 00).
REQ-014 mem_wdata0..mem_wdata3  out  8 each: lane 0..3 write bytes.
REQ-015 mem_rdata  in  32: combinational RAM read word, lane n at bits [8n+7:8n].

Function
REQ-016 The FSM SHALL have four states: IDLE, ACC0, ACC1, RESP.
- IDLE to ACC0 on accept.
- ACC0 to ACC1 when the access spans two words, otherwise to RESP.
- ACC1 to RESP.
- RESP to IDLE.
REQ-017 The request SHALL be registered on accept; later req_* changes have no effect.
REQ-018 With o = req_addr[1:0] and span = o + size(1/2/4) > 4:
- ACC0 drives word addr&~3.
- ACC1 drives word (addr&~3)+4, wrapping modulo 2^32.
REQ-019 Store lanes:
- Byte k of req_wdata goes to lane (o+k) mod 4.
- mem_wr is set for ACC0 lanes o..min(o+size,4)-1 and for ACC1 lanes 0..(o+size-5).
- Unused lanes drive 0.
REQ-020 mem_en SHALL be 1 only in ACC0/ACC1, and mem_wr SHALL be 0 for loads.
REQ-021 Load: the mem_rdata lanes needed SHALL be captured at the end of ACC0/ACC1 and reassembled, then:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes through.
REQ-022 Latency from accept edge: rsp_valid is asserted 2 cycles later for a single-word access and 3 cycles later for a split access.
REQ-023 Illegal funct3 (load 011/110/111, store >=011), or word address above 2**AWIDTH-1 on either access, SHALL go IDLE to RESP with rsp_err=1, rsp_rdata=0, and no mem_en.
REQ-024 rsp_valid SHALL be asserted in RESP only, for exactly one cycle.
REQ-025 A req_valid that is held high SHALL be accepted again in the IDLE cycle following RESP.

Reset
REQ-026 On rstn low, immediately:
- state = IDLE.
- req_ready=1.
- mem_en=0, mem_wr=0, mem_addr=0, mem_wdata*=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0.
- All capture registers cleared.
REQ-027 Reset during ACC0/ACC1/RESP SHALL abort the request with no response; ACC1 lanes are not written.

Configuration
REQ-028 Macro LSU_MISALIGN_EN:
- Defined: span>4 accesses split per REQ-016..REQ-022.
- Undefined: any access with span>4 (or LH/LHU/SH at o=3, LW/SW at o!=0) completes via REQ-023 with rsp_err=1 and no memory access, and ACC1 is not synthesized.

Structure
REQ-029 Package lsu_pkg SHALL hold the funct3 constants, the FSM state encoding, and the size decode function.
REQ-030 Sub-module lsu_lane_align (combinational) SHALL perform the store lane rotate/strobe generation and load reassembly/extension; the lsu_mem_ctrl top holds the FSM and registers.

Verification
REQ-031 Bench scenarios (RAM reset to zero):
- SW 0x11223344 @0x10 -> ACC0 mem_addr=0x10, mem_wr=1111; then LW @0x10 -> rsp_rdata=0x11223344, rsp_valid at accept+2.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; mem_wr=0010 on the store.
- With LSU_MISALIGN_EN: SW 0xAABBCCDD @0x0E -> ACC0 addr 0x0C wr=1100 lanes2,3=DD,CC; ACC1 addr 0x10 wr=0011 lanes0,1=BB,AA; LW @0x0E -> 0xAABBCCDD at accept+3.
- Without LSU_MISALIGN_EN: LH @0x03 -> rsp_err=1, mem_en never asserted.
- Load funct3=011 -> rsp_err=1 at accept+1; address 0x400 with AWIDTH=8 -> rsp_err=1.
- rstn pulsed low during ACC1 of a split SW -> ACC1 lanes unwritten, no rsp_valid, req_ready=1 after release.
